prince_ti_round_ctrl: RTL and testbench

- Round controller for the 4-share threshold-implementation (TI) PRINCE encryption core.
- Sequences the unrolled S-box layer (SBOX_STAGES register stages) and the linear/key/round-constant layer across the 12 S-layers of PRINCE.
- Requests the fresh-randomness seed that initialises the changing-of-the-guards remask chain.
- Datapath is purely controlled by this block; the block holds no cipher state itself.

---
 rtl/prince_ti_pkg.sv | 23 ++
 rtl/prince_ti_lin_decode.sv | 31 +++
 rtl/prince_ti_round_ctrl.sv | 165 ++++++++++++++++
 tb/tb_prince_ti_round_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/prince_ti_pkg.sv
// Shared encodings and constants for the 4-share TI PRINCE round controller.
package prince_ti_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StLoad,
    StSbox,
    StLin,
    StDone
  } state_e;

  localparam logic [1:0] LIN_FWD   = 2'd0;
  localparam logic [1:0] LIN_MID   = 2'd1;
  localparam logic [1:0] LIN_BWD   = 2'd2;
  localparam logic [1:0] LIN_FINAL = 2'd3;

  localparam int unsigned NUM_SLAYERS     = 12;
  localparam logic [3:0]  MID_LAYER       = 4'd5;
  localparam logic [3:0]  INV_FIRST_LAYER = 4'd6;
  localparam logic [3:0]  LAST_LAYER      = 4'(NUM_SLAYERS - 1);

endpackage

// File: rtl/prince_ti_lin_decode.sv
// Maps an S-layer index to the linear-layer mode, round-constant index and S-box direction.
module prince_ti_lin_decode
  import prince_ti_pkg::*;
(
  input  logic [3:0] layer,
  output logic [1:0] lin_mode,
  output logic [3:0] rc_idx,
  output logic       inv
);

  always_comb begin
    lin_mode = LIN_FWD;
    rc_idx   = 4'd0;
    inv      = (layer >= INV_FIRST_LAYER);
    if (layer < MID_LAYER) begin
      lin_mode = LIN_FWD;
      rc_idx   = layer + 4'd1;
    end else if (layer == MID_LAYER) begin
      // The middle reflection applies M' only; no round constant is consumed.
      lin_mode = LIN_MID;
      rc_idx   = 4'd0;
    end else if (layer < LAST_LAYER) begin
      lin_mode = LIN_BWD;
      rc_idx   = layer;
    end else begin
      lin_mode = LIN_FINAL;
      rc_idx   = LAST_LAYER;
    end
  end

endmodule

// File: rtl/prince_ti_round_ctrl.sv
// Round sequencer for the TI PRINCE core: seed request, load, 12 x (S-box stages + linear layer).
module prince_ti_round_ctrl
  import prince_ti_pkg::*;
#(
  parameter int unsigned SBOX_STAGES = 2,
  parameter int unsigned SW          = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rnd_valid,
  output logic          busy,
  output logic          done,
  output logic          rnd_req,
  output logic          guard_load,
  output logic          sel_in,
  output logic          state_en,
  output logic          sbox_en,
  output logic [SW-1:0] sbox_stage,
  output logic          inv,
  output logic          lin_en,
  output logic [1:0]    lin_mode,
  output logic [3:0]    rc_idx
);

  localparam logic [SW-1:0] LAST_STAGE = SW'(SBOX_STAGES - 1);

  state_e        state_q, state_d;
  logic [3:0]    layer_q, layer_d;
  logic [SW-1:0] stage_q, stage_d;

  logic          busy_d, done_d, rnd_req_d, sel_in_d, state_en_d, sbox_en_d;
  logic [SW-1:0] sbox_stage_d;
  logic          inv_d, lin_en_d;
  logic [1:0]    lin_mode_d;
  logic [3:0]    rc_idx_d;

  logic [1:0]    dec_lin_mode;
  logic [3:0]    dec_rc_idx;
  logic          dec_inv;

  // Decoding the next layer lets the outputs be registered yet aligned with the state.
  prince_ti_lin_decode u_lin_decode (
    .layer    (layer_d),
    .lin_mode (dec_lin_mode),
    .rc_idx   (dec_rc_idx),
    .inv      (dec_inv)
  );

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    stage_d = stage_q;
    unique case (state_q)
      StIdle: if (start) state_d = StSeed;
      StSeed: if (rnd_valid) state_d = StLoad;
      StLoad: begin
        state_d = StSbox;
        layer_d = 4'd0;
        stage_d = '0;
      end
      StSbox: begin
        if (stage_q == LAST_STAGE) state_d = StLin;
        else                       stage_d = stage_q + SW'(1);
      end
      StLin: begin
        if (layer_q == LAST_LAYER) begin
          state_d = StDone;
        end else begin
          state_d = StSbox;
          layer_d = layer_q + 4'd1;
          stage_d = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        layer_d = 4'd0;
        stage_d = '0;
      end
      default: begin
        state_d = StIdle;
        layer_d = 4'd0;
        stage_d = '0;
      end
    endcase
  end

  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    rnd_req_d    = 1'b0;
    sel_in_d     = 1'b0;
    state_en_d   = 1'b0;
    sbox_en_d    = 1'b0;
    sbox_stage_d = '0;
    inv_d        = 1'b0;
    lin_en_d     = 1'b0;
    lin_mode_d   = LIN_FWD;
    rc_idx_d     = 4'd0;
    unique case (state_d)
      StSeed: begin
        busy_d    = 1'b1;
        rnd_req_d = 1'b1;
      end
      StLoad: begin
        busy_d     = 1'b1;
        sel_in_d   = 1'b1;
        state_en_d = 1'b1;
      end
      StSbox: begin
        busy_d       = 1'b1;
        sbox_en_d    = 1'b1;
        sbox_stage_d = stage_d;
        inv_d        = dec_inv;
      end
      StLin: begin
        busy_d     = 1'b1;
        lin_en_d   = 1'b1;
        state_en_d = 1'b1;
        lin_mode_d = dec_lin_mode;
        rc_idx_d   = dec_rc_idx;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      layer_q    <= 4'd0;
      stage_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rnd_req    <= 1'b0;
      sel_in     <= 1'b0;
      state_en   <= 1'b0;
      sbox_en    <= 1'b0;
      sbox_stage <= '0;
      inv        <= 1'b0;
      lin_en     <= 1'b0;
      lin_mode   <= LIN_FWD;
      rc_idx     <= 4'd0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      stage_q    <= stage_d;
      busy       <= busy_d;
      done       <= done_d;
      rnd_req    <= rnd_req_d;
      sel_in     <= sel_in_d;
      state_en   <= state_en_d;
      sbox_en    <= sbox_en_d;
      sbox_stage <= sbox_stage_d;
      inv        <= inv_d;
      lin_en     <= lin_en_d;
      lin_mode   <= lin_mode_d;
      rc_idx     <= rc_idx_d;
    end
  end

  // The seed must be captured in the same cycle it is offered, so this one is not registered.
  assign guard_load = (state_q == StSeed) && rnd_valid;

endmodule

// File: tb/tb_prince_ti_round_ctrl.sv
// Directed bench for prince_ti_round_ctrl with SBOX_STAGES=2 and SBOX_STAGES=3 instances.
module tb_prince_ti_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2 = 1'b1, start2 = 1'b0, rv2 = 1'b0;
  logic rst3 = 1'b1, start3 = 1'b0, rv3 = 1'b0;

  logic       busy2, done2, rreq2, gl2, sel2, sen2, sben2, inv2, len2;
  logic [1:0] stg2, lm2;
  logic [3:0] rc2;
  logic       busy3, done3, rreq3, gl3, sel3, sen3, sben3, inv3, len3;
  logic [1:0] stg3, lm3;
  logic [3:0] rc3;

  prince_ti_round_ctrl #(.SBOX_STAGES(2), .SW(2)) dut (
    .clk(clk), .rst(rst2), .start(start2), .rnd_valid(rv2),
    .busy(busy2), .done(done2), .rnd_req(rreq2), .guard_load(gl2), .sel_in(sel2),
    .state_en(sen2), .sbox_en(sben2), .sbox_stage(stg2), .inv(inv2), .lin_en(len2),
    .lin_mode(lm2), .rc_idx(rc2)
  );

  prince_ti_round_ctrl #(.SBOX_STAGES(3), .SW(2)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .rnd_valid(rv3),
    .busy(busy3), .done(done3), .rnd_req(rreq3), .guard_load(gl3), .sel_in(sel3),
    .state_en(sen3), .sbox_en(sben3), .sbox_stage(stg3), .inv(inv3), .lin_en(len3),
    .lin_mode(lm3), .rc_idx(rc3)
  );

  wire [16:0] vec2 = {busy2, done2, rreq2, gl2, sel2, sen2, sben2, stg2, inv2, len2, lm2, rc2};
  wire [16:0] vec3 = {busy3, done3, rreq3, gl3, sel3, sen3, sben3, stg3, inv3, len3, lm3, rc3};

  int vectors = 0;
  int miscompares = 0;

  // Hand-derived LIN schedule per layer.
  int lm_tab [12] = '{0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 2, 3};
  int rc_tab [12] = '{1, 2, 3, 4, 5, 0, 6, 7, 8, 9, 10, 11};

  task automatic check(string tag, logic [16:0] obs, logic [16:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Expected outputs at cycle n after start (cycle 0), rnd_valid first high at cycle 1+d.
  function automatic logic [16:0] exp_vec(int n, int ss, int d);
    logic b, dn, rq, gl, sl, se, sb, iv, le;
    logic [1:0] st, lm;
    logic [3:0] rc;
    int k, per, lay, p;
    {b, dn, rq, gl, sl, se, sb, iv, le} = '0;
    st = '0; lm = '0; rc = '0;
    k = n - 3 - d;
    per = ss + 1;
    if (n >= 1 && n <= 1 + d) begin
      b = 1'b1; rq = 1'b1; gl = (n == 1 + d);
    end else if (n == 2 + d) begin
      b = 1'b1; sl = 1'b1; se = 1'b1;
    end else if (k >= 0 && k < 12 * per) begin
      lay = k / per;
      p = k % per;
      b = 1'b1;
      if (p < ss) begin
        sb = 1'b1; st = 2'(p); iv = (lay >= 6);
      end else begin
        le = 1'b1; se = 1'b1; lm = 2'(lm_tab[lay]); rc = 4'(rc_tab[lay]);
      end
    end else if (n > 0 && k == 12 * per) begin
      dn = 1'b1;
    end
    return {b, dn, rq, gl, sl, se, sb, st, iv, le, lm, rc};
  endfunction

  // One run: start at cycle 0, optional stray starts at x1/x2, optional reset at rst_at.
  task automatic run(int ss, int d, int len, int x1, int x2, int rst_at);
    logic s, v, r;
    logic [16:0] expv;
    for (int n = 0; n <= len; n++) begin
      @(negedge clk);
      s = (n == 0) || (n == x1) || (n == x2);
      v = (d == 0) ? 1'b1 : (n >= 1 + d);
      r = (n == rst_at);
      if (ss == 2) begin start2 = s; rv2 = v; rst2 = r; end
      else         begin start3 = s; rv3 = v; rst3 = r; end
      #1;
      expv = (rst_at >= 0 && n > rst_at) ? 17'd0 : exp_vec(n, ss, d);
      check($sformatf("ss%0d_d%0d_x%0d_r%0d_cyc%0d", ss, d, x1, rst_at, n),
            (ss == 2) ? vec2 : vec3, expv);
    end
    @(negedge clk);
    start2 = 1'b0; start3 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    rst3 = 1'b0;
    rv2  = 1'b1;
    #1;
    check("reset_ss2", vec2, 17'd0);
    check("reset_ss3", vec3, 17'd0);
    @(negedge clk);
    #1;
    check("idle_rv_ignored", vec2, 17'd0);

    run(2, 0, 45, -1, -1, -1);   // baseline: done at cycle 39
    run(2, 5, 50, -1, -1, -1);   // seed delayed 5 cycles: done at 44
    run(2, 0, 45, 13, 39, -1);   // stray starts in layer 3 and in DONE
    run(2, 0, 32, -1, -1, 25);   // reset during layer 7, stage 1
    run(2, 0, 42, -1, -1, -1);   // fresh run after abort
    run(3, 0, 55, -1, -1, -1);   // three-stage S-box: done at cycle 51

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
